md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset inputs.
REQ-002 The block SHALL use these ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request from EX stage, sampled only in IDLE
- op  in  4  one-hot [0]=MULT [1]=MULTU [2]=DIV [3]=DIVU
- src_a  in  32  rs_data (multiplicand / dividend)
- src_b  in  32  rt_data (multiplier / divisor)
- cancel  in  1  exception/ERET flush
- stall  out  1  pipeline stall request (combinational)
- done  out  1  one-cycle pulse; HI/LO write enable for both registers
- hi_out  out  32  HI result (product[63:32] / remainder)
- lo_out  out  32  LO result (product[31:0] / quotient)
- div_zero  out  1  pulses with done when a DIV/DIVU had src_b==0

Function
REQ-003 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-004 IDLE: start=1, cancel=0 and op one-hot valid latches op, |src_a|, |src_b| and the result signs; next state CALC, iteration counter=0.
REQ-005 start with op not one-hot (zero or multiple bits) SHALL be ignored; state stays IDLE, stall=0.
REQ-006 Signed ops (MULT, DIV) SHALL use two's-complement magnitudes; unsigned ops SHALL use operands as given.
REQ-007 CALC SHALL run exactly 32 iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide; the counter wraps 31->FIX.
REQ-008 FIX SHALL apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-009 DONE SHALL last one cycle with done=1 and hi_out/lo_out valid; next state IDLE.
REQ-010 Latency: start sampled at cycle T -> CALC T+1..T+32, FIX T+33, done=1 at T+34.
REQ-011 stall SHALL equal (state==IDLE & accepted start) | state==CALC | state==FIX; stall=0 in DONE so the instruction retires with the write.
REQ-012 start SHALL be ignored in CALC, FIX and DONE; a new request is accepted only in IDLE, earliest at T+35.
REQ-013 Divide by zero (DIV/DIVU with src_b==0) SHALL skip CALC/FIX: state goes to DONE at T+1, with hi_out=src_a, lo_out=32'hFFFFFFFF, div_zero=1, and stall high only in cycle T.
REQ-014 Signed overflow DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo_out=0x80000000, hi_out=0, via the normal 34-cycle path.
REQ-015 cancel in CALC or FIX SHALL force IDLE next cycle with no done pulse; hi_out/lo_out keep their previous values.
REQ-016 cancel in DONE SHALL suppress done and the result update.
REQ-017 cancel and start together in IDLE SHALL leave the block in IDLE.
REQ-018 hi_out/lo_out SHALL be registered, SHALL update only on the cycle done=1, and SHALL otherwise hold.
REQ-019 Only op[2]/op[3] SHALL ever raise div_zero.

Reset
REQ-020 rst=1 SHALL, at the next clock edge, set state=IDLE, counter=0, hi_out=0, lo_out=0, done=0, div_zero=0; stall SHALL be 0 while rst=1.
REQ-021 rst during CALC/FIX SHALL abort the operation with no done pulse, and reset has priority over start and cancel.

Verification
REQ-022 MULT src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done at T+34, hi_out=0x00000000, lo_out=0x00000001; MULTU same operands -> hi_out=0xFFFFFFFE, lo_out=0x00000001.
REQ-023 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; DIVU 100/7 -> lo_out=14, hi_out=2; stall high T..T+33, low at T+34.
REQ-024 DIVU src_a=0x12345678, src_b=0 -> done and div_zero at T+1, hi_out=0x12345678, lo_out=0xFFFFFFFF.
REQ-025 MULT 3*5 started, cancel at T+10 -> IDLE at T+11, no done, hi/lo unchanged; new start at T+11 accepted, done at T+45.
REQ-026 rst at T+20 mid-DIV -> IDLE, outputs zero, no done; start pulses at T+5 of an active op are ignored (single done at T+34).
REQ-027 start with op=4'b0101 or 4'b0000 -> no stall, no done.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Handshake/bus bundle between the EX stage and the
// multiply/divide sequencer.
interface md_sequencer_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  stall, done, hi_out, lo_out, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output stall, done, hi_out, lo_out, div_zero
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32-cycle radix-2
// datapath with sign fix-up and HI/LO result registers.
module md_sequencer (
  input logic           clk,
  input logic           rst,
  md_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_ok, accept;
  logic        is_div, is_sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic [63:0] neg64;

  always_comb begin
    op_ok  = (bus.op != 4'd0) &&
             ((bus.op & (bus.op - 4'd1)) == 4'd0);
    accept = bus.start & ~bus.cancel & op_ok;
    is_div = bus.op[2] | bus.op[3];
    is_sgn = bus.op[0] | bus.op[2];
    a_neg  = is_sgn & bus.src_a[31];
    b_neg  = is_sgn & bus.src_b[31];
    a_mag  = a_neg ? -bus.src_a : bus.src_a;
    b_mag  = b_neg ? -bus.src_b : bus.src_b;
    mul_sum = {1'b0, acc_hi_q} +
              (acc_lo_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh   = {acc_hi_q, acc_lo_q[31]};
    div_diff = div_sh - {1'b0, b_q};
    neg64    = -{acc_hi_q, acc_lo_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // divide by zero bypasses the datapath entirely
          if (is_div && bus.src_b == 32'd0) begin
            state_d  = DONE;
            acc_hi_d = bus.src_a;
            acc_lo_d = '1;
            dz_d     = 1'b1;
          end else begin
            state_d  = CALC;
            cnt_d    = 5'd0;
            div_d    = is_div;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = 1'b0;
            b_d      = b_mag;
            acc_hi_d = 32'd0;
            acc_lo_d = a_mag;
          end
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
          if (div_q) begin
            acc_lo_d = {acc_lo_q[30:0], ~div_diff[32]};
            acc_hi_d = div_diff[32] ? div_sh[31:0]
                                    : div_diff[31:0];
          end else begin
            {acc_hi_d, acc_lo_d} =
              {mul_sum, acc_lo_q[31:1]};
          end
        end
      end
      FIX: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (div_q) begin
            if (neg_q)  acc_lo_d = -acc_lo_q;
            if (rneg_q) acc_hi_d = -acc_hi_q;
          end else if (neg_q) begin
            {acc_hi_d, acc_lo_d} = neg64;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      b_q      <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // results are presented from the working regs during the
  // write cycle and from the committed HI/LO otherwise
  always_comb begin
    bus.done = ~rst & (state_q == DONE) & ~bus.cancel;
    bus.stall = ~rst & (((state_q == IDLE) & accept) |
                        (state_q == CALC) |
                        (state_q == FIX));
    bus.hi_out   = bus.done ? acc_hi_q : hi_q;
    bus.lo_out   = bus.done ? acc_lo_q : lo_q;
    bus.div_zero = bus.done & dz_q;
  end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_md_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  md_sequencer_if bus ();

  md_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(logic [3:0] op,
                       logic [31:0] a,
                       logic [31:0] b);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    #1;
    chk("stall_at_T", {31'd0, bus.stall}, 32'd1);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n0,
                           output int lat,
                           output int stl);
    lat = n0;
    stl = 0;
    while (!bus.done && lat < 40) begin
      if (bus.stall) stl++;
      step();
      lat++;
    end
  endtask

  task automatic run(string tag,
                     logic [3:0] op,
                     logic [31:0] a,
                     logic [31:0] b,
                     int exp_lat,
                     logic [31:0] eh,
                     logic [31:0] el,
                     logic dz);
    int lat, stl;
    issue(op, a, b);
    wait_done(1, lat, stl);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall_cnt"}, stl, exp_lat - 1);
    chk({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, "_hi"}, bus.hi_out, eh);
    chk({tag, "_lo"}, bus.lo_out, el);
    chk({tag, "_dz"}, {31'd0, bus.div_zero}, {31'd0, dz});
    step();
    chk({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_hi_hold"}, bus.hi_out, eh);
    chk({tag, "_lo_hold"}, bus.lo_out, el);
  endtask

  initial begin
    int lat, stl, ndone;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op    = 4'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    step();
    step();
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_lo", bus.lo_out, 32'd0);
    rst = 1'b0;
    step();

    run("mult_m1", 4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF,
        34, 32'h00000000, 32'h00000001, 1'b0);
    run("multu_m1", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF,
        34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("div_m7", 4'b0100, 32'hFFFFFFF9, 32'd2,
        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("divu_100_7", 4'b1000, 32'd100, 32'd7,
        34, 32'd2, 32'd14, 1'b0);
    run("divu_zero", 4'b1000, 32'h12345678, 32'd0,
        1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    run("div_ovf", 4'b0100, 32'h80000000, 32'hFFFFFFFF,
        34, 32'h00000000, 32'h80000000, 1'b0);

    // cancel at T+10 of MULT 3*5, restart at T+11
    issue(4'b0001, 32'd3, 32'd5);
    repeat (9) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("cxl_stall", {31'd0, bus.stall}, 32'd0);
    chk("cxl_done", {31'd0, bus.done}, 32'd0);
    chk("cxl_hi", bus.hi_out, 32'h00000000);
    chk("cxl_lo", bus.lo_out, 32'h80000000);
    issue(4'b0001, 32'd3, 32'd5);
    wait_done(1, lat, stl);
    chk("cxl_restart_lat", lat, 34);
    chk("cxl_restart_lo", bus.lo_out, 32'd15);
    chk("cxl_restart_hi", bus.hi_out, 32'd0);
    step();

    // start pulse at T+5 must not disturb a running op
    issue(4'b1000, 32'd100, 32'd7);
    repeat (4) step();
    bus.op    = 4'b0010;
    bus.src_a = 32'hFFFFFFFF;
    bus.src_b = 32'hFFFFFFFF;
    bus.start = 1'b1;
    #1;
    chk("busy_start_stall", {31'd0, bus.stall}, 32'd1);
    step();
    bus.start = 1'b0;
    wait_done(6, lat, stl);
    chk("busy_start_lat", lat, 34);
    chk("busy_start_lo", bus.lo_out, 32'd14);
    chk("busy_start_hi", bus.hi_out, 32'd2);
    ndone = 0;
    repeat (40) begin
      step();
      if (bus.done) ndone++;
    end
    chk("busy_start_single_done", ndone, 0);

    // cancel in DONE: no pulse, no HI/LO update
    issue(4'b0010, 32'd2, 32'd3);
    repeat (33) step();
    bus.cancel = 1'b1;
    #1;
    chk("cxd_done", {31'd0, bus.done}, 32'd0);
    chk("cxd_hi", bus.hi_out, 32'd2);
    chk("cxd_lo", bus.lo_out, 32'd14);
    step();
    bus.cancel = 1'b0;
    chk("cxd_hi_after", bus.hi_out, 32'd2);
    chk("cxd_lo_after", bus.lo_out, 32'd14);
    chk("cxd_stall", {31'd0, bus.stall}, 32'd0);

    // reset at T+20 of a DIV
    issue(4'b0100, 32'd100, 32'd7);
    repeat (19) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    step();
    rst = 1'b0;
    chk("rst_mid_hi", bus.hi_out, 32'd0);
    chk("rst_mid_lo", bus.lo_out, 32'd0);
    chk("rst_mid_idle", {31'd0, bus.stall}, 32'd0);
    ndone = 0;
    repeat (40) begin
      step();
      if (bus.done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);

    // malformed op and start+cancel stay idle
    bus.op    = 4'b0101;
    bus.start = 1'b1;
    #1;
    chk("bad_op_0101_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.op = 4'b0000;
    #1;
    chk("bad_op_0000_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.start = 1'b0;
    chk("bad_op_idle", {31'd0, bus.stall}, 32'd0);
    chk("bad_op_done", {31'd0, bus.done}, 32'd0);
    bus.op     = 4'b0001;
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    #1;
    chk("start_cxl_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    #1;
    chk("start_cxl_idle", {31'd0, bus.stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
